// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//
// APB3 completer that exposes a bank of NUM_REGS word-wide registers. It
// supports a fixed number of wait states per transfer, read-only protection
// per register, and PSLVERR for bad accesses.
//
// Parameters
//   ADDR_W      paddr width in bits (byte address)
//   DATA_W      data width; 8, 16, 32 or 64
//   NUM_REGS    number of registers, 1..2**(ADDR_W-BYTE_SH)
//   WAIT_STATES ACCESS cycles with pready=0 before completion, 0..15
//   RO_MASK     bit i set makes register i read-only
//   RESET_VAL   value every register takes on reset
//
// Ports
//   pclk     in   clock; every flop updates on the rising edge
//   prst     in   synchronous active-high reset
//   psel     in   completer select
//   penable  in   access-phase strobe
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address (ADDR_W)
//   pwdata   in   write data (DATA_W)
//   prdata   out  read data; non-zero only on a good read completion
//   pready   out  transfer completes this cycle
//   pslverr  out  transfer error; only asserted together with pready
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int                  ADDR_W      = 12,
  parameter int                  DATA_W      = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  // Number of address bits that select a byte inside one register word.
  localparam int BYTE_SH    = $clog2(DATA_W / 8);
  // Width of the word index carried by paddr.
  localparam int IDX_FULL_W = ADDR_W - BYTE_SH;
  // Width needed to select one of NUM_REGS registers.
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // NUM_REGS widened by one bit so that a full power-of-two bank still fits.
  localparam logic [IDX_FULL_W:0] NUM_REGS_EXT = NUM_REGS[IDX_FULL_W:0];
  localparam logic [3:0]          WAIT_INIT    = WAIT_STATES[3:0];

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [IDX_FULL_W-1:0] idx_full;
  logic [IDX_W-1:0]      reg_idx;
  logic                  idx_in_range;
  logic                  misaligned;
  logic                  ro_hit;
  logic                  err;

  assign idx_full     = paddr[ADDR_W-1:BYTE_SH];
  assign reg_idx      = idx_full[IDX_W-1:0];
  assign idx_in_range = ({1'b0, idx_full} < NUM_REGS_EXT);

  // With an 8-bit bus every byte address is a word address, so there are
  // no low address bits to check.
  generate
    if (BYTE_SH > 0) begin : g_align_chk
      assign misaligned = (paddr[BYTE_SH-1:0] != '0);
    end else begin : g_no_align_chk
      assign misaligned = 1'b0;
    end
  endgenerate

  // Read-only protection only matters for an index that names a real register.
  assign ro_hit = idx_in_range && RO_MASK[reg_idx];
  assign err    = !idx_in_range || misaligned || (pwrite && ro_hit);

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;
  // Set when ACCESS was entered without a SETUP phase. The transfer is still
  // completed so that the master does not hang, but it always reports an error.
  logic       proto_err_reg;
  logic       proto_err_next;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    proto_err_next = proto_err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_next     = ST_ACCESS;
          cnt_next       = WAIT_INIT;
          proto_err_next = 1'b0;
        end else if (psel && penable) begin
          // No wait states on a protocol error: answer on the next cycle.
          state_next     = ST_ACCESS;
          cnt_next       = 4'd0;
          proto_err_next = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer; nothing is written, no response.
          state_next = ST_IDLE;
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else if (penable) begin
          // Completion cycle (pready is high now).
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      proto_err_reg <= proto_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Response
  // ---------------------------------------------------------------------------
  logic wr_en;

  assign pready  = (state_reg == ST_ACCESS) && psel && penable && (cnt_reg == 4'd0);
  assign pslverr = pready && (err || proto_err_reg);
  // Address and data are taken straight off the bus in the pready cycle; the
  // master holds them stable through ACCESS, so nothing is captured at SETUP.
  assign wr_en   = pready && pwrite && !pslverr;

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] reg_file [NUM_REGS];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] data_reg;

      always_ff @(posedge pclk) begin
        if (prst) begin
          data_reg <= RESET_VAL;
        end else if (wr_en && (reg_idx == IDX_W'(gi))) begin
          data_reg <= pwdata;
        end
      end

      assign reg_file[gi] = data_reg;
    end
  endgenerate

  // Read data is forced to zero outside a successful read completion so the
  // bus never shows stale register contents. A successful read implies
  // idx_in_range, so reg_idx always names a real register here.
  assign prdata = (pready && !pwrite && !pslverr) ? reg_file[reg_idx] : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
//
// Three completers with 0, 2 and 3 wait states share one APB bus (separate
// psel per completer). A directed sequence is followed by random transfers;
// every response is compared with a register-array model of the bank that
// applies the address/error rules directly.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;

  localparam int          NDUT      = 3;
  localparam int          NREG      = 16;
  localparam int          WS_TAB [NDUT] = '{0, 2, 3};
  localparam logic [15:0] RO_MASK_C = 16'h8001;
  localparam logic [31:0] RST_VAL_C = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        prst = 1'b1;
  logic        psel_v   [NDUT];
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata_v [NDUT];
  logic        pready_v [NDUT];
  logic        pslverr_v[NDUT];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    apb_slave_regfile #(
      .ADDR_W     (12),
      .DATA_W     (32),
      .NUM_REGS   (NREG),
      .WAIT_STATES(WS_TAB[gi]),
      .RO_MASK    (RO_MASK_C),
      .RESET_VAL  (RST_VAL_C)
    ) u_dut (
      .pclk   (clk),
      .prst   (prst),
      .psel   (psel_v[gi]),
      .penable(penable),
      .pwrite (pwrite),
      .paddr  (paddr),
      .pwdata (pwdata),
      .prdata (prdata_v[gi]),
      .pready (pready_v[gi]),
      .pslverr(pslverr_v[gi])
    );
  end

  int checks   = 0;
  int failures = 0;

  // Model: expected contents of every register of every completer.
  logic [31:0] model [NDUT][NREG];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++)
      for (int r = 0; r < NREG; r++)
        model[d][r] = RST_VAL_C;
  endtask

  // Called at posedge+1; returns at posedge+1 with the bus idle.
  task automatic idle_cycle();
    for (int d = 0; d < NDUT; d++) psel_v[d] = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
  endtask

  // One complete APB transfer on completer d. Entered at posedge+1 and left
  // at posedge+1 right after the completion edge, so two calls in a row are
  // back-to-back on the bus.
  task automatic xfer(input int d, input bit wr, input logic [11:0] addr, input logic [31:0] wd);
    int          idx;
    bit          err;
    logic [31:0] exp_rd;
    idx    = int'(addr >> 2);
    err    = (idx >= NREG) || (addr[1:0] != 2'b00) || (wr && (idx < NREG) && RO_MASK_C[idx]);
    exp_rd = (!wr && !err) ? model[d][idx] : 32'h0;
    // SETUP
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    // ACCESS: WS_TAB[d] waiting cycles, then the completion cycle.
    for (int k = 0; k <= WS_TAB[d]; k++) begin
      @(negedge clk);
      if (k < WS_TAB[d]) begin
        check("wait_pready", 32'(pready_v[d]), 32'h0);
        @(posedge clk); #1;
      end else begin
        check("done_pready", 32'(pready_v[d]), 32'h1);
        check("done_pslverr", 32'(pslverr_v[d]), 32'(err));
        check("done_prdata", prdata_v[d], exp_rd);
      end
    end
    @(posedge clk); #1;
    psel_v[d] = 1'b0;
    penable   = 1'b0;
    if (wr && !err) model[d][idx] = wd;
    $display("xfer dut=%0d %s addr=0x%03h wdata=0x%08h prdata=0x%08h pslverr=%0b",
             d, wr ? "WR" : "RD", addr, wd, prdata_v[d], pslverr_v[d]);
  endtask

  task automatic read_all(input int d);
    for (int r = 0; r < NREG; r++) xfer(d, 1'b0, 12'(r * 4), 32'h0);
  endtask

  initial begin
    int          d;
    bit          wr;
    int          sel;
    logic [11:0] addr;
    logic [31:0] wd;

    for (int i = 0; i < NDUT; i++) psel_v[i] = 1'b0;
    model_reset();

    // Reset: outputs quiet while prst is high.
    prst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check("rst_pready", 32'(pready_v[i]), 32'h0);
      check("rst_pslverr", 32'(pslverr_v[i]), 32'h0);
      check("rst_prdata", prdata_v[i], 32'h0);
    end
    @(posedge clk); #1;
    prst = 1'b0;
    idle_cycle();

    // Zero-wait write then read.
    xfer(0, 1'b1, 12'h008, 32'hDEADBEEF);
    xfer(0, 1'b0, 12'h008, 32'h0);

    // Two wait states: read of reset value.
    xfer(1, 1'b0, 12'h000, 32'h0);

    // Out-of-range write and misaligned read both error; bank unchanged.
    xfer(0, 1'b1, 12'h040, 32'hCAFEF00D);
    xfer(0, 1'b0, 12'h006, 32'h0);
    read_all(0);

    // Read-only register 0 rejects writes; register 1 accepts them.
    xfer(0, 1'b1, 12'h000, 32'h12345678);
    xfer(0, 1'b0, 12'h000, 32'h0);
    xfer(0, 1'b1, 12'h004, 32'h0BAD_F00D);
    xfer(0, 1'b0, 12'h004, 32'h0);
    // Read-only register 15 (last) is readable but not writable.
    xfer(0, 1'b1, 12'h03C, 32'h1111_2222);
    xfer(0, 1'b0, 12'h03C, 32'h0);

    // Abort: psel dropped while a 3-wait-state write is still waiting.
    psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'hABCD_0123;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk); check("abort_wait0", 32'(pready_v[2]), 32'h0);
    @(posedge clk); #1;
    @(negedge clk); check("abort_wait1", 32'(pready_v[2]), 32'h0);
    @(posedge clk); #1;
    psel_v[2] = 1'b0; penable = 1'b0;
    @(negedge clk); check("abort_drop", 32'(pready_v[2]), 32'h0);
    @(posedge clk); #1;
    $display("xfer dut=2 WR addr=0x010 aborted");
    xfer(2, 1'b1, 12'h014, 32'h7777_8888);
    xfer(2, 1'b0, 12'h014, 32'h0);
    xfer(2, 1'b0, 12'h010, 32'h0);

    // Random traffic.
    for (int n = 0; n < 90; n++) begin
      d   = int'($urandom_range(0, NDUT - 1));
      wr  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)
        addr = 12'($urandom_range(12'h040, 12'hFFF));
      else if (sel == 1)
        addr = 12'($urandom_range(0, NREG - 1) * 4 + $urandom_range(1, 3));
      else
        addr = 12'($urandom_range(0, NREG - 1) * 4);
      wd = $urandom;
      xfer(d, wr, addr, wd);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    for (int i = 0; i < NDUT; i++) read_all(i);

    // Reset in the middle of a wait-stated write.
    psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h018; pwdata = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk); check("rstmid_wait", 32'(pready_v[2]), 32'h0);
    @(posedge clk); #1;
    prst = 1'b1;
    @(posedge clk); #1;
    prst = 1'b0; psel_v[2] = 1'b0; penable = 1'b0;
    model_reset();
    @(negedge clk);
    check("rstmid_pready", 32'(pready_v[2]), 32'h0);
    check("rstmid_pslverr", 32'(pslverr_v[2]), 32'h0);
    @(posedge clk); #1;
    $display("xfer dut=2 WR addr=0x018 dropped by reset");
    read_all(2);

    // Protocol error: ACCESS without SETUP on the 2-wait-state completer.
    psel_v[1] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h5555_AAAA;
    @(negedge clk);
    check("proto_idle_pready", 32'(pready_v[1]), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("proto_pready", 32'(pready_v[1]), 32'h1);
    check("proto_pslverr", 32'(pslverr_v[1]), 32'h1);
    check("proto_prdata", prdata_v[1], 32'h0);
    @(posedge clk); #1;
    psel_v[1] = 1'b0; penable = 1'b0;
    $display("xfer dut=1 WR addr=0x004 protocol error");
    xfer(1, 1'b0, 12'h004, 32'h0);
    read_all(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above stalls.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
